// File: rtl/voice_scheduler_pkg.sv
// Shared types and defaults for the voice scheduler: FSM state encoding and voice index type.
package voice_scheduler_pkg;

  localparam int N_VOICES_DEFAULT = 8;

  typedef logic [$clog2(N_VOICES_DEFAULT)-1:0] voice_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_SCALE   = 3'd3,
    ST_PRESENT = 3'd4
  } sched_state_t;

endpackage

// File: rtl/voice_scheduler_mix_saturate.sv
// Applies master volume to the voice sum and saturates it to a WIDTH-bit signed sample.
module voice_scheduler_mix_saturate #(
  parameter int WIDTH     = 24,
  parameter int ACC_W     = 27,
  parameter int VOL_WIDTH = 8
) (
  input  logic [ACC_W-1:0]     acc,
  input  logic [VOL_WIDTH-1:0] volume,
  output logic [WIDTH-1:0]     sample
);

  // One spare bit keeps the unsigned volume positive inside the signed product.
  localparam int PW = ACC_W + VOL_WIDTH + 1;

  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [PW-1:0] acc_ext;
  logic signed [PW-1:0] vol_ext;
  logic signed [PW-1:0] product;
  logic signed [PW-1:0] shifted;

  assign acc_ext = {{(PW-ACC_W){acc[ACC_W-1]}}, acc};
  assign vol_ext = {{(PW-VOL_WIDTH){1'b0}}, volume};
  assign product = acc_ext * vol_ext;
  assign shifted = product >>> (VOL_WIDTH-1);

  always_comb begin
    sample = shifted[WIDTH-1:0];
    if (shifted > SAT_MAX) begin
      sample = SAT_MAX[WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      sample = SAT_MIN[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// Per-sample sequencer: walks the enabled voices through one shared oscillator, sums,
// scales by master volume and hands one saturated sample downstream.
module voice_scheduler
  import voice_scheduler_pkg::*;
#(
  parameter int WIDTH     = 24,
  parameter int N_VOICES  = N_VOICES_DEFAULT,
  parameter int VOL_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        sample_tick,
  input  logic [N_VOICES-1:0]         voice_enable,
  input  logic [VOL_WIDTH-1:0]        volume,
  output logic                        osc_req,
  output logic [$clog2(N_VOICES)-1:0] osc_voice,
  input  logic                        osc_ready,
  input  logic                        osc_valid,
  input  logic [WIDTH-1:0]            osc_sample,
  output logic [WIDTH-1:0]            out_sample,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        overrun,
  output logic [2:0]                  state_dbg
);

  // Handshakes: a request transfers on a cycle where osc_req && osc_ready; the output
  // transfers on a cycle where out_valid && out_ready. Both sides hold their payload
  // stable while the valid/req is high and the partner is not ready.

  localparam int IDX_W = $clog2(N_VOICES);
  localparam int ACC_W = WIDTH + IDX_W;

  sched_state_t             state, state_d;
  logic [IDX_W-1:0]         idx;
  logic [N_VOICES-1:0]      en_q;
  logic [VOL_WIDTH-1:0]     vol_q;
  logic signed [ACC_W-1:0]  acc;
  logic [WIDTH-1:0]         mixed;

  logic start_frame;
  logic advance;
  logic take_sample;
  logic last_voice;
  logic overrun_d;

  assign last_voice = (idx == IDX_W'(N_VOICES-1));
  assign state_dbg  = state;

  always_comb begin
    state_d     = state;
    osc_req     = 1'b0;
    osc_voice   = '0;
    start_frame = 1'b0;
    advance     = 1'b0;
    take_sample = 1'b0;
    busy        = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (sample_tick) begin
          start_frame = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!en_q[idx]) begin
          advance = 1'b1;
          state_d = last_voice ? ST_SCALE : ST_ISSUE;
        end else begin
          osc_req   = 1'b1;
          osc_voice = idx;
          if (osc_ready) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (osc_valid) begin
          take_sample = 1'b1;
          advance     = 1'b1;
          state_d     = last_voice ? ST_SCALE : ST_ISSUE;
        end
      end
      ST_SCALE: state_d = ST_PRESENT;
      ST_PRESENT: begin
        // A tick landing on the accept cycle chains straight into the next frame.
        if (out_ready) begin
          if (sample_tick) begin
            start_frame = 1'b1;
            state_d     = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    overrun_d = sample_tick && busy && !start_frame;
  end

  voice_scheduler_mix_saturate #(
    .WIDTH     (WIDTH),
    .ACC_W     (ACC_W),
    .VOL_WIDTH (VOL_WIDTH)
  ) u_mix (
    .acc    (acc),
    .volume (vol_q),
    .sample (mixed)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      idx        <= '0;
      en_q       <= '0;
      vol_q      <= '0;
      acc        <= '0;
      out_sample <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state   <= state_d;
      overrun <= overrun_d;
      if (start_frame) begin
        en_q  <= voice_enable;
        vol_q <= volume;
        acc   <= '0;
        idx   <= '0;
      end else if (advance) begin
        idx <= idx + IDX_W'(1);
      end
      if (take_sample) begin
        acc <= acc + {{IDX_W{osc_sample[WIDTH-1]}}, osc_sample};
      end
      if (state == ST_SCALE) begin
        out_sample <= mixed;
        out_valid  <= 1'b1;
      end else if (state == ST_PRESENT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: oscillator responder model, output scoreboard, vector table.
module tb_voice_scheduler;

  localparam int W = 24;

  logic          clk;
  logic          rstn;
  logic          sample_tick;
  logic [7:0]    voice_enable;
  logic [7:0]    volume;
  logic          osc_req;
  logic [2:0]    osc_voice;
  logic          osc_ready;
  logic          osc_valid;
  logic [W-1:0]  osc_sample;
  logic [W-1:0]  out_sample;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          overrun;
  logic [2:0]    state_dbg;

  voice_scheduler dut (
    .clk          (clk),
    .rstn         (rstn),
    .sample_tick  (sample_tick),
    .voice_enable (voice_enable),
    .volume       (volume),
    .osc_req      (osc_req),
    .osc_voice    (osc_voice),
    .osc_ready    (osc_ready),
    .osc_valid    (osc_valid),
    .osc_sample   (osc_sample),
    .out_sample   (out_sample),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .overrun      (overrun),
    .state_dbg    (state_dbg)
  );

  typedef struct packed {
    logic [7:0]   en;
    logic [7:0]   vol;
    logic [W-1:0] smp;
    logic [W-1:0] step;
    logic [W-1:0] exp;
    logic [3:0]   lat;
    logic [3:0]   rdel;
    logic [3:0]   hold;
    logic         glitch;
    logic         use_model;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  logic [2:0]   hs_q[$];

  // Frame configuration seen by the oscillator and output models
  logic [W-1:0] cur_smp = '0;
  logic [W-1:0] cur_step = '0;
  int           cur_lat = 1;
  int           cur_rdel = 0;
  int           cur_hold = 0;
  logic         cur_glitch = 1'b0;

  int out_count = 0;
  int ovr_count = 0;
  int valid_cyc = 0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [7:0] en, input logic [7:0] vol,
                                         input logic [W-1:0] smp, input logic [W-1:0] step);
    longint sum;
    longint p;
    logic [W-1:0] s;
    sum = 0;
    for (int v = 0; v < 8; v++) begin
      if (en[v]) begin
        s = smp + W'(v) * step;
        sum += longint'($signed(s));
      end
    end
    p = (sum * longint'(vol)) >>> 7;
    if (p > 64'sd8388607) p = 64'sd8388607;
    else if (p < -64'sd8388608) p = -64'sd8388608;
    return p[W-1:0];
  endfunction

  function automatic vec_t mk(input logic [7:0] en, input logic [7:0] vol, input logic [W-1:0] smp,
                              input logic [W-1:0] step, input logic [W-1:0] exp, input int lat,
                              input int rdel, input int hold, input logic glitch, input logic use_model);
    vec_t v;
    v.en = en; v.vol = vol; v.smp = smp; v.step = step; v.exp = exp;
    v.lat = 4'(lat); v.rdel = 4'(rdel); v.hold = 4'(hold);
    v.glitch = glitch; v.use_model = use_model;
    return v;
  endfunction

  // Oscillator responder: grants after cur_rdel cycles, returns sample cur_lat cycles later.
  initial begin
    int wcnt;
    int cnt;
    int pv;
    logic pend;
    logic [2:0] held_voice;
    osc_ready = 1'b0; osc_valid = 1'b0; osc_sample = '0;
    wcnt = 0; cnt = 0; pv = 0; pend = 1'b0; held_voice = '0;
    forever begin
      @(negedge clk);
      osc_ready = 1'b0;
      osc_valid = 1'b0;
      if (!rstn) wcnt = 0;
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          osc_valid  = 1'b1;
          osc_sample = cur_smp + W'(pv) * cur_step;
          pend = 1'b0;
        end
      end else if (osc_req && rstn) begin
        if (wcnt == 0) begin
          held_voice = osc_voice;
        end else begin
          checks++;
          if (osc_voice !== held_voice) begin
            errors++;
            $display("FAIL osc_voice_stable: got %0d expected %0d", osc_voice, held_voice);
          end
        end
        if (wcnt >= cur_rdel) begin
          osc_ready = 1'b1;
          pend = 1'b1;
          cnt = cur_lat;
          pv = int'(osc_voice);
          hs_q.push_back(osc_voice);
          wcnt = 0;
          if (cur_glitch) begin
            osc_valid  = 1'b1;
            osc_sample = 24'h3FFFFF;
          end
        end else begin
          wcnt++;
        end
      end else if (wcnt != 0 && rstn) begin
        checks++;
        errors++;
        $display("FAIL osc_req_stable: got 0 expected 1");
        wcnt = 0;
      end
    end
  end

  // Output monitor / scoreboard: holds out_ready low cur_hold cycles, then accepts.
  initial begin
    logic seen;
    int held;
    logic [W-1:0] first_sample;
    logic [W-1:0] e;
    seen = 1'b0; held = 0; first_sample = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      out_ready = 1'b0;
      if (rstn && overrun) ovr_count++;
      if (!rstn) seen = 1'b0;
      if (rstn && out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          valid_cyc = cyc;
          held = 0;
          first_sample = out_sample;
        end else begin
          checks++;
          if (out_sample !== first_sample) begin
            errors++;
            $display("FAIL out_sample_hold: got %0h expected %0h", out_sample, first_sample);
          end
        end
        if (held >= cur_hold) begin
          out_ready = 1'b1;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got %0h expected none", out_sample);
          end else begin
            e = exp_q.pop_front();
            if (out_sample !== e) begin
              errors++;
              $display("FAIL out_sample: got %0h expected %0h", out_sample, e);
            end
          end
          out_count++;
          seen = 1'b0;
        end else begin
          held++;
        end
      end
    end
  end

  task automatic run_frame(input vec_t vc, input int extra_tick_at, input int exp_ovr, input string tag);
    int o0, ov0, tick_cyc, n, p, k, exp_lat;
    logic done;
    logic [W-1:0] e;
    cur_smp = vc.smp; cur_step = vc.step; cur_lat = int'(vc.lat);
    cur_rdel = int'(vc.rdel); cur_hold = int'(vc.hold); cur_glitch = vc.glitch;
    hs_q.delete();
    o0 = out_count; ov0 = ovr_count;
    e = vc.use_model ? model(vc.en, vc.vol, vc.smp, vc.step) : vc.exp;
    exp_q.push_back(e);
    voice_enable = vc.en;
    volume = vc.vol;
    @(negedge clk);
    sample_tick = 1'b1;
    tick_cyc = cyc;
    @(negedge clk);
    sample_tick = 1'b0;
    // Frame is already latched; scrambling the inputs must not affect it.
    voice_enable = ~vc.en;
    volume = ~vc.vol;
    n = 1; done = 1'b0;
    while (!done && n < 800) begin
      if (extra_tick_at != 0 && n == extra_tick_at) sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      n++;
      if (out_count != o0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: got no output expected 1 output", tag);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
    p = $countones(vc.en);
    exp_lat = 2 + (8 - p) + p * (int'(vc.rdel) + int'(vc.lat) + 1);
    check({tag, "_latency"}, 32'(valid_cyc - tick_cyc), 32'(exp_lat));
    check({tag, "_outputs"}, 32'(out_count - o0), 32'd1);
    check({tag, "_overrun"}, 32'(ovr_count - ov0), 32'(exp_ovr));
    check({tag, "_hs_count"}, 32'(hs_q.size()), 32'(p));
    k = 0;
    for (int v = 0; v < 8; v++) begin
      if (vc.en[v] && k < hs_q.size()) begin
        check({tag, "_hs_voice"}, 32'(hs_q[k]), 32'(v));
        k++;
      end
    end
  endtask

  vec_t vecs[8];

  initial begin
    int o0;
    int n;
    rstn = 1'b0; sample_tick = 1'b0; voice_enable = '0; volume = '0;

    vecs[0] = mk(8'hFF, 8'd128, 24'd1000,   24'd0,     24'd8000,   1, 0, 3, 1'b0, 1'b0);
    vecs[1] = mk(8'h81, 8'd128, 24'h7FFFFF, 24'd0,     24'h7FFFFF, 2, 1, 0, 1'b0, 1'b0);
    vecs[2] = mk(8'h00, 8'd128, 24'd1234,   24'd0,     24'd0,      1, 0, 1, 1'b0, 1'b0);
    vecs[3] = mk(8'h0F, 8'd255, 24'hC2F700, 24'd0,     24'h800000, 1, 0, 0, 1'b0, 1'b0);
    vecs[4] = mk(8'hF0, 8'd64,  24'hC2F700, 24'd0,     24'h85EE00, 3, 2, 1, 1'b0, 1'b0);
    vecs[5] = mk(8'hA5, 8'd200, 24'h000100, 24'h000010, 24'd1950,  1, 0, 0, 1'b1, 1'b0);
    for (int i = 6; i < 8; i++) begin
      vecs[i] = mk(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 24'($urandom),
                   24'($urandom_range(0, 65535)), 24'd0, $urandom_range(1, 3),
                   $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 1'b1);
    end

    #1;
    check("rst_osc_req", 32'(osc_req), 32'd0);
    check("rst_osc_voice", 32'(osc_voice), 32'd0);
    check("rst_out_sample", 32'(out_sample), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i], 0, 0, $sformatf("vec%0d", i));
    end

    // osc_ready held off 5 cycles, plus a stray tick mid-frame
    run_frame(mk(8'h24, 8'd128, 24'd5000, 24'd0, 24'd10000, 3, 5, 2, 1'b0, 1'b0), 10, 1, "overrun");

    // Reset while waiting on the oscillator; its late result must be ignored.
    cur_smp = 24'd100; cur_step = '0; cur_lat = 8; cur_rdel = 0; cur_hold = 0; cur_glitch = 1'b0;
    voice_enable = 8'hFF; volume = 8'd128;
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    n = 0;
    while (state_dbg != 3'd2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reach_wait", 32'(state_dbg), 32'd2);
    rstn = 1'b0;
    #1;
    check("midrst_osc_req", 32'(osc_req), 32'd0);
    check("midrst_osc_voice", 32'(osc_voice), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_sample", 32'(out_sample), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    o0 = out_count;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (12) @(negedge clk);
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_outputs", 32'(out_count - o0), 32'd0);
    run_frame(vecs[0], 0, 0, "post_rst");

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/voice_scheduler.md
Name: voice_scheduler

Overview:
- Per-sample sequencer sharing one oscillator datapath among N_VOICES voices.
- On each sample tick it requests one sample per enabled voice, accumulates them, applies master volume, saturates to WIDTH bits and presents one mixed sample to dac_transmitter.
- Sits between receiver_control_unit (voice enables, volume) and the shared oscillator / DAC path.

Parameters:
- WIDTH, 24: signed sample width of oscillator output and mixed output.
- N_VOICES, 8: number of voices time-multiplexed per sample (power of two, >=2).
- VOL_WIDTH, 8: unsigned volume width; unity gain = 2^(VOL_WIDTH-1).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- sample_tick  in  1  one-cycle pulse per sample period, already synchronous to clk.
- voice_enable  in  N_VOICES  per-voice enable mask.
- volume  in  VOL_WIDTH  master gain, unsigned.
- osc_req  out  1  request to shared oscillator.
- osc_voice  out  $clog2(N_VOICES)  voice index for current request.
- osc_ready  in  1  oscillator accepts the request this cycle.
- osc_valid  in  1  oscillator result valid, one-cycle pulse.
- osc_sample  in  WIDTH  signed oscillator result.
- out_sample  out  WIDTH  signed mixed sample.
- out_valid  out  1  out_sample valid.
- out_ready  in  1  downstream accepts out_sample.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  one-cycle pulse when sample_tick is dropped.

Behaviour:
- Reset (asynchronous, rstn=0): state IDLE; all outputs 0 (osc_req, osc_voice, out_sample, out_valid, busy, overrun); accumulator and index cleared. Reset mid-frame abandons the frame; any in-flight osc_valid after reset release is ignored in IDLE.
- States: IDLE, ISSUE, WAIT, SCALE, PRESENT.
- IDLE: on sample_tick, capture voice_enable and volume into frame registers, clear accumulator, set index=0, go to ISSUE. Changes to the inputs mid-frame have no effect until the next tick.
- ISSUE:
  - If the captured enable bit for index is 0, skip it. Advance index and stay in ISSUE, or go to SCALE after index N_VOICES-1. One cycle per skipped voice.
  - Otherwise drive osc_req=1 and osc_voice=index. Hold both stable until osc_ready=1, then go to WAIT.
- WAIT: osc_req=0. On osc_valid, add sign-extended osc_sample to the accumulator. The accumulator is WIDTH+$clog2(N_VOICES) bits, so it cannot overflow. Then advance index to ISSUE, or to SCALE after the last voice. An osc_valid in the same cycle as the osc_ready handshake is not accepted; the result is taken from WAIT onward.
- SCALE: one cycle. product = acc * {1'b0, volume}, arithmetic shift right by VOL_WIDTH-1, saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Register the result into out_sample, set out_valid=1, go to PRESENT.
- PRESENT: hold out_sample and out_valid until out_ready=1. The cycle out_ready=1 is seen, clear out_valid and return to IDLE. A sample_tick in that same cycle starts a new frame directly; it is not an overrun.
- All voices disabled: frame passes through ISSUE in N_VOICES cycles; out_sample=0.
- Overrun: sample_tick while busy=1 (except in the PRESENT accept cycle) pulses overrun for 1 cycle. The tick is dropped and the current frame continues unaffected.
- Latency, with all voices enabled, oscillator ready same cycle and valid L cycles later: 1 + N_VOICES*(L+1) + 1 cycles from tick to out_valid.

Decomposition:
- Shared package constants.svh gets N_VOICES_DEFAULT and the sched_state_t enum. It also gets a typedef voice_idx_t = logic [$clog2(N_VOICES)-1:0].
- One sub-module, mix_saturate: combinational multiply, shift and saturate used in SCALE, testable on its own.

Test Plan:
- All 8 voices enabled, each returns 24'sd1000, volume=128 -> out_sample=8000, out_valid held until out_ready.
- Voices 0 and 7 enabled only, samples 24'sh7FFFFF and 24'sh7FFFFF, volume=128 -> exactly 2 osc_req handshakes with osc_voice 0 then 7; out_sample=24'sh7FFFFF (saturated).
- voice_enable=0 -> no osc_req; out_sample=0 after 1+8+1 cycles.
- Four voices at -24'sd4000000, volume=255 -> out_sample=24'sh800000 (negative saturation). Volume=64 -> -8000000.
- osc_ready held low 5 cycles -> osc_req and osc_voice stable throughout. A second sample_tick during WAIT -> overrun pulses once; output count per frame unchanged.
- rstn asserted in WAIT -> all outputs 0 immediately. A later stray osc_valid is ignored. The next tick produces a correct fresh frame.
